// File: rtl/jtframe_vtimer_pkg.sv
// ============================================================================
// Module : jtframe_vtimer_pkg
// Brief  : Shared timing helpers and default 384x264 CRT mode constants.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package jtframe_vtimer_pkg;

    localparam int c_HW         = 9;
    localparam int c_VW         = 9;
    localparam int c_HCNT_START = 0;
    localparam int c_HCNT_END   = 383;
    localparam int c_HB_START   = 256;
    localparam int c_HB_END     = 0;
    localparam int c_HS_START   = 300;
    localparam int c_HS_END     = 332;
    localparam int c_VCNT_START = 0;
    localparam int c_VCNT_END   = 263;
    localparam int c_VB_START   = 224;
    localparam int c_VB_END     = 0;
    localparam int c_VS_START   = 240;
    localparam int c_VS_END     = 243;
    localparam int c_WDW        = 8;

    // Window membership; a start above the end describes a window that wraps.
    function automatic logic in_win(input int c, input int s, input int e);
        if (s < e)      return (c >= s) && (c < e);
        else if (s > e) return (c >= s) || (c < e);
        else            return 1'b0;
    endfunction

    function automatic logic in_range(input int c, input int s, input int e);
        return (c >= s) && (c <= e);
    endfunction

    // Set/clear flag update evaluated against the counter value being entered.
    function automatic logic flag_upd(input logic cur, input logic chg,
                                      input int c, input int s, input int e);
        if (s == e)      return 1'b0;
        else if (!chg)   return cur;
        else if (c == s) return 1'b1;
        else if (c == e) return 1'b0;
        else             return cur;
    endfunction

endpackage

`default_nettype wire

// File: rtl/jtframe_cen_watchdog.sv
// ============================================================================
// Module : jtframe_cen_watchdog
// Brief  : Saturating idle counter that flags a missing pixel clock enable.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module jtframe_cen_watchdog #(
    parameter int WDW = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic pxl_cen,
    output logic cen_lost
);

    localparam logic [WDW-1:0] c_SAT = '1;

    logic [WDW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || pxl_cen) begin
            r_cnt <= '0;
        end else if (r_cnt != c_SAT) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cen_lost = (r_cnt == c_SAT);

endmodule

`default_nettype wire

// File: rtl/jtframe_cen_vtimer.sv
// ============================================================================
// Module : jtframe_cen_vtimer
// Brief  : H/V video timing generator advanced by a fractional pixel CEN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module jtframe_cen_vtimer
    import jtframe_vtimer_pkg::*;
#(
    parameter int HW         = c_HW,
    parameter int VW         = c_VW,
    parameter int HCNT_START = c_HCNT_START,
    parameter int HCNT_END   = c_HCNT_END,
    parameter int HB_START   = c_HB_START,
    parameter int HB_END     = c_HB_END,
    parameter int HS_START   = c_HS_START,
    parameter int HS_END     = c_HS_END,
    parameter int VCNT_START = c_VCNT_START,
    parameter int VCNT_END   = c_VCNT_END,
    parameter int VB_START   = c_VB_START,
    parameter int VB_END     = c_VB_END,
    parameter int VS_START   = c_VS_START,
    parameter int VS_END     = c_VS_END,
    parameter int WDW        = c_WDW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pxl_cen,
    output logic [HW-1:0] hcnt,
    output logic [VW-1:0] vcnt,
    output logic          hblank,
    output logic          vblank,
    output logic          LHBL,
    output logic          LVBL,
    output logic          hsync,
    output logic          vsync,
    output logic          frame,
    output logic          cen_lost
);

    localparam logic [HW-1:0] c_HSTART = HW'(HCNT_START);
    localparam logic [HW-1:0] c_HEND   = HW'(HCNT_END);
    localparam logic [VW-1:0] c_VSTART = VW'(VCNT_START);
    localparam logic [VW-1:0] c_VEND   = VW'(VCNT_END);

    logic [HW-1:0] r_hcnt, w_hnext;
    logic [VW-1:0] r_vcnt, w_vnext;
    logic          r_hblank, r_vblank, r_hsync, r_vsync, r_frame;
    logic          w_lost, w_adv, w_hwrap, w_hchg, w_vchg;

    jtframe_cen_watchdog #(
        .WDW      (WDW)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .pxl_cen  (pxl_cen),
        .cen_lost (w_lost)
    );

    // A CEN seen while the watchdog is tripped only rearms it.
    assign w_adv = pxl_cen & ~w_lost;

    always_comb begin
        w_hnext = r_hcnt;
        w_vnext = r_vcnt;
        w_hwrap = 1'b0;
        if (w_adv) begin
            if (r_hcnt == c_HEND || !in_range(int'(r_hcnt), HCNT_START, HCNT_END)) begin
                w_hnext = c_HSTART;
                w_hwrap = 1'b1;
            end else begin
                w_hnext = r_hcnt + 1'b1;
            end
            if (!in_range(int'(r_vcnt), VCNT_START, VCNT_END)) begin
                w_vnext = c_VSTART;
            end else if (w_hwrap) begin
                w_vnext = (r_vcnt == c_VEND) ? c_VSTART : r_vcnt + 1'b1;
            end
        end
    end

    assign w_hchg = w_adv && (w_hnext != r_hcnt);
    assign w_vchg = w_adv && (w_vnext != r_vcnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hcnt   <= c_HSTART;
            r_vcnt   <= c_VSTART;
            r_hblank <= in_win(HCNT_START, HB_START, HB_END);
            r_hsync  <= in_win(HCNT_START, HS_START, HS_END);
            r_vblank <= in_win(VCNT_START, VB_START, VB_END);
            r_vsync  <= in_win(VCNT_START, VS_START, VS_END);
            r_frame  <= 1'b0;
        end else begin
            r_hcnt   <= w_hnext;
            r_vcnt   <= w_vnext;
            r_hblank <= flag_upd(r_hblank, w_hchg, int'(w_hnext), HB_START, HB_END);
            r_hsync  <= flag_upd(r_hsync,  w_hchg, int'(w_hnext), HS_START, HS_END);
            r_vblank <= flag_upd(r_vblank, w_vchg, int'(w_vnext), VB_START, VB_END);
            r_vsync  <= flag_upd(r_vsync,  w_vchg, int'(w_vnext), VS_START, VS_END);
            r_frame  <= w_vchg && (w_vnext == c_VSTART);
        end
    end

    assign hcnt     = r_hcnt;
    assign vcnt     = r_vcnt;
    assign hblank   = r_hblank;
    assign vblank   = r_vblank;
    assign LHBL     = ~r_hblank;
    assign LVBL     = ~r_vblank;
    assign hsync    = r_hsync;
    assign vsync    = r_vsync;
    assign frame    = r_frame;
    assign cen_lost = w_lost;

endmodule

`default_nettype wire

// File: tb/tb_jtframe_cen_vtimer.sv
// ============================================================================
// Module : tb_jtframe_cen_vtimer
// Brief  : Directed self-checking bench for the CEN-driven video timer.
// Rev    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_jtframe_cen_vtimer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pxl_cen = 1'b0;
    logic [3:0] hcnt;
    logic [2:0] vcnt;
    logic       hblank, vblank, LHBL, LVBL, hsync, vsync, frame, cen_lost;

    int   total = 0;
    int   bad = 0;
    int   mh = 0;
    int   mv = 0;
    logic ev_frame = 1'b0;

    always #5 clk = ~clk;

    jtframe_cen_vtimer #(
        .HW(4), .VW(3),
        .HCNT_START(0), .HCNT_END(9), .HB_START(6), .HB_END(0), .HS_START(7), .HS_END(9),
        .VCNT_START(0), .VCNT_END(5), .VB_START(4), .VB_END(0), .VS_START(4), .VS_END(5),
        .WDW(8)
    ) dut (
        .clk(clk), .rst(rst), .pxl_cen(pxl_cen),
        .hcnt(hcnt), .vcnt(vcnt), .hblank(hblank), .vblank(vblank),
        .LHBL(LHBL), .LVBL(LVBL), .hsync(hsync), .vsync(vsync),
        .frame(frame), .cen_lost(cen_lost)
    );

    function automatic logic exp_win(input int c, input int s, input int e);
        if (s < e)      return (c >= s) && (c < e);
        else if (s > e) return (c >= s) || (c < e);
        else            return 1'b0;
    endfunction

    // One clk with the given CEN; expected position advances on accepted CENs.
    task automatic cyc(input logic c);
        pxl_cen = c;
        @(negedge clk);
        ev_frame = 1'b0;
        if (c && !rst) begin
            if (mh == 9) begin
                mh = 0;
                if (mv == 5) begin mv = 0; ev_frame = 1'b1; end
                else mv = mv + 1;
            end else begin
                mh = mh + 1;
            end
        end
    endtask

    task automatic do_cen(input int gap);
        cyc(1'b1);
        repeat (gap - 1) cyc(1'b0);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cyc(1'b0);
        cyc(1'b1);
        rst = 1'b0;
        mh = 0; mv = 0;
        total++; if (hcnt !== 4'd0) begin bad++; $display("FAIL reset_hcnt: got %0d want 0", hcnt); end
        total++; if (vcnt !== 3'd0) begin bad++; $display("FAIL reset_vcnt: got %0d want 0", vcnt); end
        total++; if ({hblank, vblank, hsync, vsync} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags: got hb/vb/hs/vs=%b want 0000", {hblank, vblank, hsync, vsync});
        end
        total++; if ({LHBL, LVBL} !== 2'b11) begin bad++; $display("FAIL reset_L: got %b want 11", {LHBL, LVBL}); end
        total++; if ({frame, cen_lost} !== 2'b00) begin bad++; $display("FAIL reset_frame_lost: got %b want 00", {frame, cen_lost}); end
        repeat (10) do_cen(3);
        total++; if (hcnt !== 4'd0 || vcnt !== 3'd1) begin
            bad++; $display("FAIL tenth_cen: got h=%0d v=%0d want h=0 v=1", hcnt, vcnt);
        end
    endtask

    task automatic test_line;
        for (int i = 0; i < 30; i++) begin
            cyc(i % 3 == 0);
            total++; if (hcnt !== 4'(mh)) begin bad++; $display("FAIL line_hcnt: got %0d want %0d", hcnt, mh); end
            total++; if (hblank !== exp_win(mh, 6, 0)) begin bad++; $display("FAIL line_hblank h=%0d: got %b want %b", mh, hblank, exp_win(mh, 6, 0)); end
            total++; if (hsync !== exp_win(mh, 7, 9)) begin bad++; $display("FAIL line_hsync h=%0d: got %b want %b", mh, hsync, exp_win(mh, 7, 9)); end
            total++; if (LHBL !== ~exp_win(mh, 6, 0)) begin bad++; $display("FAIL line_LHBL h=%0d: got %b want %b", mh, LHBL, ~exp_win(mh, 6, 0)); end
        end
    endtask

    task automatic test_frame;
        int nf = 0;
        for (int i = 0; i < 180; i++) begin
            cyc(i % 3 == 0);
            if (frame === 1'b1) nf++;
            total++; if (vcnt !== 3'(mv)) begin bad++; $display("FAIL frame_vcnt: got %0d want %0d", vcnt, mv); end
            total++; if (vblank !== exp_win(mv, 4, 0) || LVBL !== ~exp_win(mv, 4, 0)) begin
                bad++; $display("FAIL frame_vblank v=%0d: got vb=%b LVBL=%b", mv, vblank, LVBL);
            end
            total++; if (vsync !== exp_win(mv, 4, 5)) begin bad++; $display("FAIL frame_vsync v=%0d: got %b want %b", mv, vsync, exp_win(mv, 4, 5)); end
            total++; if (frame !== ev_frame) begin bad++; $display("FAIL frame_pulse i=%0d: got %b want %b", i, frame, ev_frame); end
        end
        total++; if (nf !== 1) begin bad++; $display("FAIL frame_count: got %0d want 1", nf); end
    endtask

    task automatic test_cen_every_clk;
        int nf = 0;
        for (int i = 0; i < 70; i++) begin
            cyc(1'b1);
            if (frame === 1'b1) nf++;
            total++; if (hcnt !== 4'(mh) || vcnt !== 3'(mv)) begin
                bad++; $display("FAIL fast_pos: got h=%0d v=%0d want h=%0d v=%0d", hcnt, vcnt, mh, mv);
            end
            total++; if ({hblank, hsync, vblank, vsync} !== {exp_win(mh, 6, 0), exp_win(mh, 7, 9), exp_win(mv, 4, 0), exp_win(mv, 4, 5)}) begin
                bad++; $display("FAIL fast_flags h=%0d v=%0d: got %b", mh, mv, {hblank, hsync, vblank, vsync});
            end
            total++; if (frame !== ev_frame) begin bad++; $display("FAIL fast_frame i=%0d: got %b want %b", i, frame, ev_frame); end
        end
        total++; if (nf !== 1) begin bad++; $display("FAIL fast_frame_count: got %0d want 1", nf); end
    endtask

    task automatic test_watchdog;
        cyc(1'b1);
        repeat (250) cyc(1'b0);
        total++; if (cen_lost !== 1'b0) begin bad++; $display("FAIL wd_early: got %b want 0", cen_lost); end
        total++; if (hcnt !== 4'(mh) || vcnt !== 3'(mv)) begin
            bad++; $display("FAIL wd_frozen: got h=%0d v=%0d want h=%0d v=%0d", hcnt, vcnt, mh, mv);
        end
        repeat (10) cyc(1'b0);
        total++; if (cen_lost !== 1'b1) begin bad++; $display("FAIL wd_lost: got %b want 1", cen_lost); end
        total++; if (hcnt !== 4'(mh) || hblank !== exp_win(mh, 6, 0)) begin
            bad++; $display("FAIL wd_hold: got h=%0d hb=%b want h=%0d", hcnt, hblank, mh);
        end
        // First returning CEN only rearms the watchdog; position stays put.
        pxl_cen = 1'b1;
        @(negedge clk);
        total++; if (cen_lost !== 1'b0) begin bad++; $display("FAIL wd_recover: got %b want 0", cen_lost); end
        total++; if (hcnt !== 4'(mh)) begin bad++; $display("FAIL wd_rearm_hold: got %0d want %0d", hcnt, mh); end
        cyc(1'b1);
        total++; if (hcnt !== 4'(mh) || vcnt !== 3'(mv)) begin
            bad++; $display("FAIL wd_resume: got h=%0d v=%0d want h=%0d v=%0d", hcnt, vcnt, mh, mv);
        end
    endtask

    task automatic test_mid_reset;
        rst = 1'b1;
        cyc(1'b0);
        rst = 1'b0;
        mh = 0; mv = 0;
        repeat (37) do_cen(3);
        total++; if (hcnt !== 4'd7 || vcnt !== 3'd3 || hsync !== 1'b1 || hblank !== 1'b1) begin
            bad++; $display("FAIL pre_reset: got h=%0d v=%0d hs=%b hb=%b want 7 3 1 1", hcnt, vcnt, hsync, hblank);
        end
        rst = 1'b1;
        cyc(1'b1);
        rst = 1'b0;
        mh = 0; mv = 0;
        total++; if (hcnt !== 4'd0 || vcnt !== 3'd0) begin
            bad++; $display("FAIL mid_reset_pos: got h=%0d v=%0d want 0 0", hcnt, vcnt);
        end
        total++; if ({hblank, hsync, vblank, vsync, frame} !== 5'b00000) begin
            bad++; $display("FAIL mid_reset_flags: got %b want 00000", {hblank, hsync, vblank, vsync, frame});
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_line;
        test_frame;
        test_cen_every_clk;
        test_watchdog;
        test_mid_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
